// File: rtl/alu_sequencer.sv
// alu_sequencer: queues ALU requests, issues them one at a time and registers each result for a valid/ready consumer.
// Ports: CLK/CLR clock and async reset; in_* request handshake and operands;
// alu_A/alu_B/alu_S drive the ALU, alu_Y/C/V/Z are its result; out_* result
// handshake and captured flags; busy = not idle; fifo_count = queued requests.
module alu_sequencer #(
    parameter int DWIDTH     = 16,
    parameter int OPWIDTH    = 4,
    parameter int LATENCY    = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          CLK,
    input  logic                          CLR,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DWIDTH-1:0]             in_a,
    input  logic [DWIDTH-1:0]             in_b,
    input  logic [OPWIDTH-1:0]            in_op,
    output logic [DWIDTH-1:0]             alu_A,
    output logic [DWIDTH-1:0]             alu_B,
    output logic [OPWIDTH-1:0]            alu_S,
    input  logic [DWIDTH-1:0]             alu_Y,
    input  logic                          alu_C,
    input  logic                          alu_V,
    input  logic                          alu_Z,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DWIDTH-1:0]             out_y,
    output logic                          out_c,
    output logic                          out_v,
    output logic                          out_z,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 2 * DWIDTH + OPWIDTH;
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t        state, next_state;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [3:0]    cnt;
    logic          push, pop;

    // Pointers are exactly AW bits wide, so they wrap modulo the power-of-two depth.
    always_ff @(posedge CLK) begin
        if (push)
            mem[wr_ptr] <= {in_a, in_b, in_op};
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                fifo_count <= fifo_count + 1'b1;
            else if (pop && !push)
                fifo_count <= fifo_count - 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = (fifo_count != '0) ? WAIT : IDLE;
            WAIT:    next_state = (cnt == '0) ? HOLD : WAIT;
            HOLD:    next_state = out_ready ? IDLE : HOLD;
            default: next_state = IDLE;
        endcase
    end

    // in_ready uses only the registered count, so a full FIFO refuses a push
    // even in a cycle that also pops.
    always_comb begin
        busy     = state != IDLE;
        in_ready = !CLR && (fifo_count < FULL);
        pop      = (state == IDLE) && (fifo_count != '0);
        push     = in_valid && in_ready;
    end

    // cnt is loaded with LATENCY-1 at issue so the capture lands exactly
    // LATENCY edges after the operands change.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            alu_A     <= '0;
            alu_B     <= '0;
            alu_S     <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_y     <= '0;
            out_c     <= 1'b0;
            out_v     <= 1'b0;
            out_z     <= 1'b0;
        end else begin
            if (pop) begin
                {alu_A, alu_B, alu_S} <= mem[rd_ptr];
                cnt                   <= 4'(LATENCY - 1);
            end
            if (state == WAIT) begin
                if (cnt != '0)
                    cnt <= cnt - 1'b1;
                else begin
                    {out_y, out_c, out_v, out_z} <= {alu_Y, alu_C, alu_V, alu_Z};
                    out_valid                    <= 1'b1;
                end
            end
            if (state == HOLD && out_ready)
                out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench for alu_sequencer driving a pipelined behavioural ALU.
module tb_alu_sequencer;
    logic        CLK = 0, CLR = 1;
    logic        in_valid = 0, in_ready;
    logic [15:0] in_a = 0, in_b = 0;
    logic [3:0]  in_op = 0;
    logic [15:0] alu_A, alu_B, alu_Y;
    logic [3:0]  alu_S;
    logic        alu_C, alu_V, alu_Z;
    logic        out_valid, out_ready = 1;
    logic [15:0] out_y;
    logic        out_c, out_v, out_z, busy;
    logic [2:0]  fifo_count;

    int          n_chk = 0, n_pass = 0, n_out = 0, cyc = 0;
    logic [18:0] sb [$];
    int          tq [$];
    logic [18:0] p1, p2;

    alu_sequencer #(.DWIDTH(16), .OPWIDTH(4), .LATENCY(3), .FIFO_DEPTH(4)) dut (
        .CLK(CLK), .CLR(CLR), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .alu_A(alu_A), .alu_B(alu_B), .alu_S(alu_S),
        .alu_Y(alu_Y), .alu_C(alu_C), .alu_V(alu_V), .alu_Z(alu_Z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_y(out_y), .out_c(out_c), .out_v(out_v), .out_z(out_z),
        .busy(busy), .fifo_count(fifo_count)
    );

    always #5 CLK = ~CLK;

    // Returns {y, c, v, z}: op0 add, op1 subtract (c = borrow), op2 and, else xor.
    function automatic logic [18:0] alu_f(input logic [15:0] a, b, input logic [3:0] op);
        logic [16:0] r;
        logic        v;
        r = (op == 0) ? {1'b0, a} + {1'b0, b} : (op == 1) ? {1'b0, a} - {1'b0, b} :
            (op == 2) ? {1'b0, a & b} : {1'b0, a ^ b};
        v = (op == 0) ? (a[15] == b[15]) && (r[15] != a[15]) :
            (op == 1) ? (a[15] != b[15]) && (r[15] != a[15]) : 1'b0;
        return {r[15:0], r[16], v, r[15:0] == 16'h0};
    endfunction

    // ALU result settles two edges after its operands change, so only a
    // capture on the third edge sees the new value.
    always @(posedge CLK) begin
        p1 <= alu_f(alu_A, alu_B, alu_S);
        p2 <= p1;
    end
    assign {alu_Y, alu_C, alu_V, alu_Z} = p2;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    always @(posedge CLK) begin
        if (!CLR && in_valid && in_ready)
            sb.push_back(alu_f(in_a, in_b, in_op));
        if (!CLR && out_valid && out_ready) begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0)
                chk("result", {out_y, out_c, out_v, out_z}, sb.pop_front());
            tq.push_back(cyc);
            n_out++;
        end
        cyc++;
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [15:0] a, b, input logic [3:0] op);
        int t = 0;
        in_a = a; in_b = b; in_op = op; in_valid = 1;
        while (!in_ready && t < 100) begin
            @(negedge CLK);
            t++;
        end
        if (!in_ready)
            chk("send_wait", in_ready, 1);
        @(posedge CLK);
        @(negedge CLK);
        in_valid = 0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || busy || fifo_count != 0) && t < 300) begin
            @(negedge CLK);
            t++;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        int n0, seen;
        repeat (2) @(negedge CLK);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_A", alu_A, 0);
        chk("rst_out_y", out_y, 0);
        CLR = 0;
        @(negedge CLK);

        send(16'd3, 16'd4, 4'd0);
        @(negedge CLK);
        chk("issue_alu_A", alu_A, 3);
        chk("issue_busy", busy, 1);
        @(negedge CLK);
        chk("lat_e2", out_valid, 0);
        @(negedge CLK);
        chk("lat_e3", out_valid, 0);
        @(negedge CLK);
        chk("lat_e4", out_valid, 1);
        chk("out_y_add", out_y, 7);
        @(negedge CLK);
        chk("one_cycle", out_valid, 0);
        drain();

        send(16'hFFFF, 16'h0001, 4'd0);
        send(16'h7FFF, 16'h0001, 4'd0);
        send(16'h8000, 16'h0001, 4'd1);
        drain();

        out_ready = 0;
        n0 = n_out;
        for (int i = 0; i < 5; i++)
            send(16'(i * 100 + 1), 16'(i + 7), 4'(i % 4));
        chk("full_count", fifo_count, 4);
        chk("full_ready", in_ready, 0);
        fork
            send(16'h1234, 16'h4321, 4'd3);
            begin
                repeat (3) begin
                    @(negedge CLK);
                    chk("held_count", fifo_count, 4);
                    chk("held_ready", in_ready, 0);
                    chk("held_valid", out_valid, 1);
                end
                out_ready = 1;
            end
        join
        drain();
        chk("bp_delivered", n_out - n0, 6);

        send(16'h1111, 16'h2222, 4'd1);
        @(negedge CLK);
        chk("stab_issue", alu_A, 16'h1111);
        send(16'hAAAA, 16'h5555, 4'd2);
        repeat (2) begin
            chk("stab_A", alu_A, 16'h1111);
            chk("stab_B", alu_B, 16'h2222);
            chk("stab_S", alu_S, 1);
            @(negedge CLK);
        end
        drain();

        n0 = n_out;
        send(16'd10, 16'd20, 4'd0);
        send(16'd30, 16'd40, 4'd0);
        #2 CLR = 1;
        #1;
        chk("clr_alu_A", alu_A, 0);
        chk("clr_count", fifo_count, 0);
        chk("clr_busy", busy, 0);
        chk("clr_ready", in_ready, 0);
        chk("clr_out_valid", out_valid, 0);
        sb.delete();
        repeat (2) @(negedge CLK);
        CLR = 0;
        seen = 0;
        repeat (20) begin
            @(negedge CLK);
            if (out_valid)
                seen++;
        end
        chk("clr_no_result", seen, 0);
        chk("clr_no_deliver", n_out - n0, 0);

        tq.delete();
        for (int i = 0; i < 8; i++)
            send(16'(i * 4099), 16'(i * 31 + 5), 4'(i % 4));
        drain();
        chk("tp_count", tq.size(), 8);
        for (int i = 1; i < tq.size(); i++)
            chk("tp_gap", tq[i] - tq[i-1], 5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
